data_mem_unit: RTL and testbench

//  Data memory for the multi-cycle CPU, upstream of the write-back data bus register:
//  its DataOut feeds that register's memory-data input during the MEM->WB transition.

---
 rtl/data_mem_unit.sv | 163 ++++++++++++++++
 tb/tb_data_mem_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// Byte-addressed, big-endian data memory with byte/half/word access, a configurable
// load latency and a single-cycle Ready/MisAlign completion pulse.
module data_mem_unit #(
    parameter int DEPTH  = 128,
    parameter int RD_LAT = 1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        mRD,
    input  logic        mWR,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] DAddr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        Ready,
    output logic        MisAlign
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [31:0]   dout_q, dout_d;
    logic          ready_q, ready_d;
    logic          mis_q, mis_d;

    logic [7:0]    mem [DEPTH];
    logic          mem_we;
    logic [3:0]    lane_en;
    logic [7:0]    lane_data [4];
    logic [31:0]   wdata_aligned;

    logic [AW-1:0] rd_idx;
    logic [1:0]    rd_size;
    logic          rd_uns;
    logic [7:0]    rd_byte [4];
    logic [31:0]   rd_val;
    logic          in_misaligned;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^DAddr[31:AW];
    assign in_misaligned = ((Size == 2'b01) && DAddr[0]) ||
                           (Size[1] && (DAddr[1:0] != 2'b00));

    // In IDLE the read port follows the live request (RD_LAT=1); later it uses the latched one.
    assign rd_idx  = (state_q == IDLE) ? DAddr[AW-1:0] : addr_q;
    assign rd_size = (state_q == IDLE) ? Size : size_q;
    assign rd_uns  = (state_q == IDLE) ? Unsigned : uns_q;

    // Store data left-justified so lane 0 (lowest address) always holds the MSB.
    assign wdata_aligned = Size[1] ? DataIn :
                           Size[0] ? {DataIn[15:0], 16'b0} : {DataIn[7:0], 24'b0};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi]   = mem[rd_idx + AW'(gi)];
            assign lane_data[gi] = wdata_aligned[31-8*gi -: 8];
            assign lane_en[gi]   = (gi == 0) || Size[1] || (Size[0] && (gi == 1));
        end
    endgenerate

    always_comb begin
        rd_val = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
        case (rd_size)
            2'b00:   rd_val = rd_uns ? {24'b0, rd_byte[0]} : {{24{rd_byte[0][7]}}, rd_byte[0]};
            2'b01:   rd_val = rd_uns ? {16'b0, rd_byte[0], rd_byte[1]}
                                     : {{16{rd_byte[0][7]}}, rd_byte[0], rd_byte[1]};
            default: rd_val = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        dout_d  = dout_q;
        ready_d = 1'b0;
        mis_d   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mWR || mRD) begin
                    addr_d = DAddr[AW-1:0];
                    size_d = Size;
                    uns_d  = Unsigned;
                end
                if (mWR) begin
                    mem_we  = !in_misaligned && !Reset;
                    mis_d   = in_misaligned;
                    ready_d = 1'b1;
                    state_d = RESP;
                end else if (mRD) begin
                    if (in_misaligned) begin
                        mis_d   = 1'b1;
                        ready_d = 1'b1;
                        state_d = RESP;
                    end else if (RD_LAT == 1) begin
                        dout_d  = rd_val;
                        ready_d = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    dout_d  = rd_val;
                    ready_d = 1'b1;
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            dout_q  <= '0;
            ready_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            mis_q   <= mis_d;
        end
    end

    // Storage is deliberately outside the reset domain so its contents survive Reset.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[DAddr[AW-1:0] + AW'(i)] <= lane_data[i];
                end
            end
        end
    end

    assign DataOut  = dout_q;
    assign Ready    = ready_q;
    assign MisAlign = mis_q;
endmodule

// File: tb/tb_data_mem_unit.sv
// Two instances (RD_LAT=1 and RD_LAT=3) share stimulus; a byte-array model predicts each
// completion, and a negedge monitor checks every Ready pulse against its instance's queue.
module tb_data_mem_unit;
    localparam int DEPTH = 128;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        rd = 1'b0, wr = 1'b0, uns = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0, din = '0;
    logic [31:0] dout0, dout1;
    logic        rdy0, rdy1, mis0, mis1;

    always #5 CLK = ~CLK;

    data_mem_unit #(.DEPTH(DEPTH), .RD_LAT(1)) u_lat1 (
        .CLK(CLK), .Reset(rst), .mRD(rd), .mWR(wr), .Size(size), .Unsigned(uns),
        .DAddr(addr), .DataIn(din), .DataOut(dout0), .Ready(rdy0), .MisAlign(mis0));

    data_mem_unit #(.DEPTH(DEPTH), .RD_LAT(3)) u_lat3 (
        .CLK(CLK), .Reset(rst), .mRD(rd), .mWR(wr), .Size(size), .Unsigned(uns),
        .DAddr(addr), .DataIn(din), .DataOut(dout1), .Ready(rdy1), .MisAlign(mis1));

    typedef struct {
        logic [31:0] dout;
        logic        mis;
        int          rcyc;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [7:0]  mm [DEPTH];
    logic [31:0] mdout = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int k, input logic r, input logic [31:0] d, input logic m);
        exp_t e;
        if (r !== 1'b1) return;
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL spurious_ready dut%0d: Ready=1 at cycle %0d, want 0", k, cyc);
            return;
        end
        if (k == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        $display("dut%0d ready cyc=%0d dout=%h mis=%0d", k, cyc, d, m);
        chk32($sformatf("dout_dut%0d", k), d, e.dout);
        chk32($sformatf("misalign_dut%0d", k), {31'b0, m}, {31'b0, e.mis});
        chk32($sformatf("ready_cycle_dut%0d", k), 32'(cyc), 32'(e.rcyc));
    endtask

    always @(negedge CLK) begin
        mon(0, rdy0, dout0, mis0);
        mon(1, rdy1, dout1, mis1);
    end

    function automatic bit m_mis(input logic [31:0] a, input logic [1:0] s);
        return (s == 2'b01 && a[0]) || (s >= 2'b10 && (a % 4) != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] s, input logic u);
        int b;
        logic [7:0] by;
        logic [15:0] h;
        b  = int'(a % DEPTH);
        by = mm[b];
        h  = {mm[b], mm[(b + 1) % DEPTH]};
        if (s == 2'b00) return u ? {24'b0, by} : {{24{by[7]}}, by};
        if (s == 2'b01) return u ? {16'b0, h} : {{16{h[15]}}, h};
        return {mm[b], mm[(b + 1) % DEPTH], mm[(b + 2) % DEPTH], mm[(b + 3) % DEPTH]};
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        int b;
        b = int'(a % DEPTH);
        if (s >= 2'b10) begin
            for (int i = 0; i < 4; i++) mm[(b + i) % DEPTH] = 8'(d >> (8 * (3 - i)));
        end else if (s == 2'b01) begin
            mm[b] = d[15:8];
            mm[(b + 1) % DEPTH] = d[7:0];
        end else begin
            mm[b] = d[7:0];
        end
    endtask

    // mode 0: plain op; 1: extra mRD pulse while the RD_LAT=3 copy is busy; 2: Reset while busy
    task automatic op(input bit w, input bit r, input logic [1:0] s, input bit u,
                      input logic [31:0] a, input logic [31:0] d, input int mode);
        int e;
        bit mis;
        exp_t x;
        @(negedge CLK);
        wr = w; rd = r; size = s; uns = u; addr = a; din = d;
        e = cyc + 1;
        mis = m_mis(a, s);
        if (w) begin
            if (!mis) m_store(a, s, d);
            x = '{mdout, mis, e};
            q0.push_back(x);
            q1.push_back(x);
        end else if (r) begin
            if (mis) begin
                x = '{mdout, 1'b1, e};
                q0.push_back(x);
                q1.push_back(x);
            end else begin
                mdout = m_load(a, s, u);
                x = '{mdout, 1'b0, e};
                q0.push_back(x);
                x.rcyc = e + 2;
                if (mode != 2) q1.push_back(x);
            end
        end
        @(negedge CLK);
        wr = 1'b0; rd = 1'b0;
        if (mode == 1) begin
            rd = 1'b1;
            addr = $urandom & 32'hFFFF_FFFC;
            @(negedge CLK);
            rd = 1'b0;
        end
        if (mode == 2) begin
            #1 rst = 1'b1;
            mdout = '0;
            @(negedge CLK);
            chk32("reset_abort_dout_dut0", dout0, 32'h0);
            chk32("reset_abort_dout_dut1", dout1, 32'h0);
            chk32("reset_abort_ready_dut1", {31'b0, rdy1}, 32'h0);
            @(negedge CLK);
            rst = 1'b0;
            repeat (4) @(negedge CLK);
        end
        #2;
        for (int i = 0; i < 40 && (q0.size() != 0 || q1.size() != 0); i++) begin
            @(negedge CLK);
            #2;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: pending dut0=%0d dut1=%0d, want 0", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
    endtask

    initial begin
        logic [1:0]  s;
        logic [31:0] a;
        int          kind;
        repeat (2) @(negedge CLK);
        chk32("rst_dout0", dout0, 32'h0);
        chk32("rst_dout1", dout1, 32'h0);
        chk32("rst_ready0", {31'b0, rdy0}, 32'h0);
        chk32("rst_ready1", {31'b0, rdy1}, 32'h0);
        chk32("rst_mis0", {31'b0, mis0}, 32'h0);
        chk32("rst_mis1", {31'b0, mis1}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i += 4) op(1, 0, 2'b10, 0, 32'(i), $urandom, 0);

        op(1, 0, 2'b10, 0, 8, 32'h80C3_1234, 0);
        op(0, 1, 2'b10, 0, 8, 0, 0);
        chk32("t1_word_dut0", dout0, 32'h80C3_1234);
        op(0, 1, 2'b00, 0, 8, 0, 0);
        chk32("t2_sbyte_dut0", dout0, 32'hFFFF_FF80);
        op(0, 1, 2'b00, 1, 8, 0, 0);
        chk32("t2_ubyte_dut1", dout1, 32'h0000_0080);
        op(0, 1, 2'b01, 0, 10, 0, 0);
        chk32("t2_shalf_dut0", dout0, 32'h0000_1234);
        op(0, 1, 2'b10, 0, 6, 0, 0);
        chk32("t3_misload_hold_dut1", dout1, 32'h0000_1234);
        op(1, 0, 2'b01, 0, 9, 32'h0000_FFFF, 0);
        op(0, 1, 2'b11, 0, DEPTH + 8, 0, 0);
        chk32("t3_wrap_reread_dut0", dout0, 32'h80C3_1234);
        op(0, 1, 2'b10, 0, 8, 0, 1);
        op(1, 1, 2'b10, 0, 0, 32'hDEAD_BEEF, 0);
        chk32("t5_store_hold_dut1", dout1, 32'h80C3_1234);
        op(0, 1, 2'b10, 0, 0, 0, 0);
        chk32("t5_load_dut1", dout1, 32'hDEAD_BEEF);
        op(0, 1, 2'b10, 0, 8, 0, 2);
        op(0, 1, 2'b10, 0, 8, 0, 0);
        chk32("t6_after_reset_dut1", dout1, 32'h80C3_1234);

        for (int n = 0; n < 300; n++) begin
            s = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            kind = $urandom_range(0, 3);
            case (kind)
                0: op(1, 0, s, $urandom_range(0, 1) == 1, a, $urandom, 0);
                1: op(0, 1, s, $urandom_range(0, 1) == 1, a, 0, 0);
                2: op(1, 1, s, 0, a, $urandom, 0);
                default: op(0, 1, s, $urandom_range(0, 1) == 1, a, 0, m_mis(a, s) ? 0 : 1);
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
